// File: rtl/brnch_hzrd_ctrl.sv
// Sequencing controller for the ID-stage branch checker: RAW hazard stalls,
// operand forwarding select, redirect/flush generation and performance counters.
module brnch_hzrd_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_is_brnch,
    input  logic [2:0]       id_rs,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [2:0]       ex_rd,
    input  logic             mem_wr_en,
    input  logic             mem_is_load,
    input  logic [2:0]       mem_rd,
    input  logic             take_branch,
    input  logic             pipe_freeze,
    input  logic             id_flush,
    input  logic             cnt_clr,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic [1:0]       fwd_sel,
    output logic             pc_sel_brnch,
    output logic             flush_if_id,
    output logic [CNT_W-1:0] brnch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StStall   = 2'b01,
        StResolve = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] brnch_cnt_q, taken_cnt_q, stall_cnt_q;
    logic             exm, memm, is_br;
    logic [1:0]       need;
    logic             stall, resolve;

    always_comb begin
        exm   = ex_wr_en & (ex_rd == id_rs);
        memm  = mem_wr_en & (mem_rd == id_rs);
        is_br = id_valid & id_is_brnch;
        if (exm & ex_is_load) begin
            need = 2'd2;
        end else if (exm | (memm & mem_is_load)) begin
            need = 2'd1;
        end else begin
            need = 2'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        resolve = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_br) begin
                    case (need)
                        2'd0: resolve = 1'b1;
                        2'd1: begin
                            stall   = 1'b1;
                            state_d = StResolve;
                        end
                        default: begin
                            stall   = 1'b1;
                            state_d = StStall;
                        end
                    endcase
                end
            end
            StStall: begin
                stall   = 1'b1;
                state_d = StResolve;
            end
            StResolve: begin
                resolve = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (id_flush) begin
            state_d = StIdle;
            stall   = 1'b0;
            resolve = 1'b0;
        end
        // Freeze wins over flush: the whole pipeline, including this FSM, holds.
        if (pipe_freeze) begin
            state_d = state_q;
            stall   = 1'b0;
            resolve = 1'b0;
        end
        if (rst) begin
            stall   = 1'b0;
            resolve = 1'b0;
        end
    end

    always_comb begin
        stall_if_id  = stall;
        bubble_id_ex = stall;
        pc_sel_brnch = resolve & take_branch;
        flush_if_id  = resolve & take_branch;
        fwd_sel      = 2'b00;
        if (resolve) begin
            if (exm & ~ex_is_load) begin
                fwd_sel = 2'b01;
            end else if (memm) begin
                fwd_sel = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            brnch_cnt_q <= '0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                brnch_cnt_q <= '0;
                taken_cnt_q <= '0;
                stall_cnt_q <= '0;
            end else begin
                // stall/resolve are already zero under freeze, so counters hold.
                if (resolve) begin
                    brnch_cnt_q <= brnch_cnt_q + CNT_W'(1);
                end
                if (resolve & take_branch) begin
                    taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                end
                if (stall) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign brnch_cnt = brnch_cnt_q;
    assign taken_cnt = taken_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule
